// File: rtl/main_bus_master_pkg.sv
// Shared definitions for the main bus master: FSM state type, burst
// geometry and memory page base addresses.
package main_bus_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } bus_master_state_t;

    localparam int BURST_LEN = 4;
    localparam int WORD_W    = 16;

    // Page bases; the page number lives in address bits [15:12].
    localparam logic [15:0] MEMPAGE0 = 16'h0000;
    localparam logic [15:0] MEMPAGE1 = 16'h1000;
    localparam logic [15:0] MEMPAGE2 = 16'h2000;
    localparam logic [15:0] MEMPAGE3 = 16'h3000;

    // Page number of a bus address.
    function automatic logic [3:0] page_of(input logic [15:0] addr);
        return addr[15:12];
    endfunction

endpackage

// File: rtl/main_bus_master.sv
// Main bus master: takes one 4-word burst request from the CPU side and
// frames it on the main bus as one address phase plus four data phases.
// Read data and a one-cycle completion pulse are returned to the requester.
// Optional build macro MAIN_BUS_MASTER_B2B_EN: also accept a new request in
// the last data beat, giving a 5-cycle back-to-back issue period.
module main_bus_master
    import main_bus_master_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_rw,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [ADDR_W*BURST_LEN-1:0] req_wdata,
    output logic                        rsp_valid,
    output logic                        rsp_rw,
    output logic [ADDR_W*BURST_LEN-1:0] rsp_rdata,
    output logic                        AddrValid,
    output logic                        rw,
    output logic [ADDR_W-1:0]           AddrData_o,
    output logic                        AddrData_oe,
    input  logic [ADDR_W-1:0]           AddrData_i
);

    localparam int                DATA_BITS = ADDR_W * BURST_LEN;
    localparam int                BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    bus_master_state_t      state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   rw_q, rw_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [DATA_BITS-1:0]   rbuf_q, rbuf_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_rw_q, rsp_rw_d;
    logic                   ready_c;
    logic                   accept;

    // Request acceptance window: IDLE, plus the last beat when back-to-back is built in.
    always_comb begin
        ready_c = (state_q == IDLE);
`ifdef MAIN_BUS_MASTER_B2B_EN
        if (state_q == DATA && beat_q == LAST_BEAT) begin
            ready_c = 1'b1;
        end
`endif
    end

    // Ready is forced low while reset is held, since the FSM already sits in IDLE then.
    assign req_ready = ready_c & resetN;
    assign accept    = req_valid & req_ready;

    // Next-state logic: burst sequencing, read word collection and request capture.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_rw_d    = rsp_rw_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ADDR: begin
                state_d = DATA;
                beat_d  = '0;
            end
            DATA: begin
                if (rw_q) begin
                    rbuf_d[beat_q*ADDR_W +: ADDR_W] = AddrData_i;
                end
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rw_d    = rw_q;
                    // Returned data only changes when a whole read has landed.
                    if (rw_q) begin
                        rdata_d = rbuf_d;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request overrides the return to IDLE (back-to-back case).
        if (accept) begin
            state_d = ADDR;
            rw_d    = req_rw;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
    end

    // State and holding registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rw_q    <= rsp_rw_d;
        end
    end

    // Bus drive: address phase, then write words; the bus is released on read beats.
    always_comb begin
        AddrValid   = 1'b0;
        AddrData_oe = 1'b0;
        AddrData_o  = '0;
        if (state_q == ADDR) begin
            AddrValid   = 1'b1;
            AddrData_oe = 1'b1;
            AddrData_o  = addr_q;
        end else if (state_q == DATA && !rw_q) begin
            AddrData_oe = 1'b1;
            AddrData_o  = wdata_q[beat_q*ADDR_W +: ADDR_W];
        end
    end

    assign rw        = rw_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rw    = rsp_rw_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/main_bus_master.md
Name: main_bus_master

Overview:
- Upstream bus master for the memory subsystem: accepts one 4-word burst request (read or write) from a CPU-side valid/ready port.
- Sequences the request onto the main bus as one address phase followed by 4 data phases, the framing the memory_if slave consumes.
- Returns read data and a completion pulse to the requester.
- Replaces the directed bench master in the system build.

Parameters:
- ADDR_W, 16, bus address/data width (page in [15:12], offset in [11:0])
- BURST_LEN, 4, data phases per transaction (fixed by bus protocol; do not override)

Ports:
- clk  in  1  system clock, rising edge
- resetN  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request this cycle
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  16  burst base address
- req_wdata  in  64  write words; beat i = req_wdata[16*i +: 16]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rw  out  1  type of completed transaction
- rsp_rdata  out  64  read words, same packing as req_wdata
- AddrValid  out  1  address-phase strobe
- rw  out  1  bus transaction direction
- AddrData_o  out  16  bus address/data driven by master
- AddrData_oe  out  1  master drives AddrData this cycle
- AddrData_i  in  16  bus address/data as resolved (slave read data)

Behaviour:
- Reset (async, resetN=0): state IDLE. req_ready=0 while in reset, then 1 after release. All other outputs 0. In-flight transaction dropped with no rsp_valid.
- States: IDLE, ADDR, DATA (2-bit beat counter 0..3).
- IDLE: req_ready=1. On req_valid&&req_ready, capture rw/addr/wdata into holding registers and go to ADDR. Later changes on req_* are ignored.
- ADDR (1 cycle): AddrValid=1, AddrData_oe=1, AddrData_o=captured addr unmodified (slave increments), rw=captured rw. Go to DATA with beat=0.
- DATA, write: AddrData_oe=1, AddrData_o=wdata word[beat], AddrValid=0, rw held.
- DATA, read: AddrData_oe=0, AddrData_o=0. AddrData_i sampled at the end of each beat into rsp_rdata[16*beat +: 16].
- DATA beat 3: at the closing edge, rsp_valid is set for exactly 1 cycle and rsp_rw is set. Next state is IDLE.
- Latency: accept edge → ADDR 1 cycle → 4 data cycles → rsp_valid in the cycle after beat 3 (6 cycles from accept to rsp_valid).
- Min issue period: 6 cycles (ADDR, D0-D3, IDLE).
- rsp_rdata holds until the next read completes. Writes never modify it.
- Outputs not driven in a state are 0 (AddrData_o=0 when oe=0). rw holds its last value in IDLE.
- req_valid with req_ready=0: no effect; the request must be held by the requester.
- The page field is not checked; non-selected pages are ignored by slaves, and reads of them return whatever AddrData_i carries.

Optional Feature:
- Macro: MAIN_BUS_MASTER_B2B_EN
- Defined: req_ready is also 1 during DATA beat 3. An acceptance there goes straight to ADDR, giving a 5-cycle back-to-back period. rsp_valid for the old transaction coincides with the new ADDR cycle.
- Undefined: req_ready only in IDLE; 6-cycle period as above.

Decomposition:
- Add to mcDefs: bus_master_state_t enum {IDLE, ADDR, DATA}, BURST_LEN=4, WORD_W=16.
- Existing page constants (MEMPAGE1 etc.) are used by the bench for addressing.
- No sub-module needed; single module with FSM plus beat counter. A wrapper connects the discrete bus ports to main_bus_if.master.

Test Plan:
- Write burst: req_rw=0, addr=16'h1000 (MEMPAGE1 base), wdata=64'h4444_3333_2222_1111 → ADDR cycle shows AddrValid=1, AddrData_o=16'h1000; beats drive 1111, 2222, 3333, 4444 with oe=1; rsp_valid pulse 6 cycles after accept, rsp_rw=0.
- Read-back: read addr=16'h1000 after the write → oe=0 in data beats; rsp_rdata=64'h4444_3333_2222_1111, rsp_rw=1.
- Two back-to-back requests (req_valid held high, addr 16'h1000 then 16'h1004) → second ADDR 6 cycles after the first without the macro, 5 cycles with MAIN_BUS_MASTER_B2B_EN; data correct for both.
- req_addr/req_wdata changed during DATA → bus still shows captured values; req_ready=0 throughout ADDR and beats 0-2.
- resetN pulsed low during beat 2 of a write → all outputs 0 immediately, no rsp_valid; after release req_ready=1 and a new read of 16'h1008 completes normally.
- Write to 16'h100C then read 16'h100C with a 0-word pattern 64'h0 → rsp_rdata=0; previous rsp_rdata is overwritten only at read completion, not at the write.
